// File: rtl/stream_key_matcher.sv
`default_nettype none
// ============================================================================
//  Module      : stream_key_matcher (with helper comparator_eq)
//  Description : Sequential key search over a valid/ready word stream.
//                A key is loaded while idle. A burst of len words is then
//                accepted one per cycle. Each accepted word is compared
//                against the key through a structural equality comparator.
//                When the burst ends, a one-cycle done pulse presents the
//                number of matches, a found flag and the 0-based index of
//                the first matching word.
//  Optional    : `define MATCH_EARLY_EXIT_EN to end the burst on the first
//                matching word. Words after that match are left on the
//                stream and are not accepted.
//  Ports       : clk          rising-edge clock
//                rst          asynchronous, active-low reset
//                key_load     capture key_in (idle only)
//                key_in       search key, N bits
//                start        begin a burst of len words (idle only)
//                len          burst length, CW bits, sampled on start
//                in_valid     upstream word valid
//                in_data      upstream word, N bits
//                in_ready     word accepted when in_valid & in_ready
//                busy         search in progress
//                done         one-cycle result-valid pulse
//                match_count  number of words equal to the key (saturating)
//                found        match_count != 0
//                first_idx    index of first matching word, 0 if none
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// comparator_eq : purely combinational N-bit equality. Each bit pair is XORed
// and the result is NOR-reduced.
// ----------------------------------------------------------------------------
module comparator_eq #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         eq
);

  logic [N-1:0] w_diff;

  for (genvar i = 0; i < N; i++) begin : g_bits
    assign w_diff[i] = a[i] ^ b[i];
  end

  assign eq = ~|w_diff;

endmodule

// ----------------------------------------------------------------------------
// stream_key_matcher : top-level search stage
// ----------------------------------------------------------------------------
module stream_key_matcher #(
  parameter int N  = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_load,
  input  logic [N-1:0]  key_in,
  input  logic          start,
  input  logic [CW-1:0] len,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  output logic          in_ready,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] match_count,
  output logic          found,
  output logic [CW-1:0] first_idx
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [CW-1:0] C_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;

  logic [N-1:0]  r_key;
  logic [CW-1:0] r_remaining;
  logic [CW-1:0] r_index;
  logic [CW-1:0] r_match_count;
  logic          r_found;
  logic [CW-1:0] r_first_idx;
  logic          r_done;

  logic          w_in_ready;
  logic          w_busy;
  logic          w_hs;
  logic          w_eq;
  logic          w_last;
  logic          w_cnt_sat;
  logic          w_accept_start;

  // Single shared comparator: every accepted word is checked against the
  // registered key.
  comparator_eq #(
    .N (N)
  ) u_cmp (
    .a  (in_data),
    .b  (r_key),
    .eq (w_eq)
  );

  assign w_hs           = in_valid & w_in_ready;
  assign w_last         = (r_remaining == C_ONE);
  assign w_cnt_sat      = &r_match_count;
  assign w_accept_start = (r_state == S_IDLE) & start;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          // A zero-length burst produces results with no accepted words.
          w_next_state = (len == '0) ? S_DONE : S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (w_hs) begin
`ifdef MATCH_EARLY_EXIT_EN
          if (w_eq || w_last) begin
            w_next_state = S_DONE;
          end
`else
          if (w_last) begin
            w_next_state = S_DONE;
          end
`endif
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode: in_ready and busy follow the current state directly
  // --------------------------------------------------------------------------
  always_comb begin
    w_in_ready = 1'b0;
    w_busy     = 1'b0;
    case (r_state)
      S_SEARCH: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
      end
      default: begin
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Key register: writable only while idle. When key_load and start coincide,
  // the new key is already in place for the first comparison.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key <= '0;
    end else if ((r_state == S_IDLE) && key_load) begin
      r_key <= key_in;
    end
  end

  // --------------------------------------------------------------------------
  // Burst bookkeeping and result accumulation
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_remaining   <= '0;
      r_index       <= '0;
      r_match_count <= '0;
      r_found       <= 1'b0;
      r_first_idx   <= '0;
    end else if (w_accept_start) begin
      r_remaining   <= len;
      r_index       <= '0;
      r_match_count <= '0;
      r_found       <= 1'b0;
      r_first_idx   <= '0;
    end else if ((r_state == S_SEARCH) && w_hs) begin
      if (w_eq) begin
        if (!w_cnt_sat) begin
          r_match_count <= r_match_count + C_ONE;
        end
        if (!r_found) begin
          r_found     <= 1'b1;
          r_first_idx <= r_index;
        end
      end
      r_index     <= r_index + C_ONE;
      r_remaining <= r_remaining - C_ONE;
    end
  end

  // done is registered: it rises on the same edge that enters DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (w_next_state == S_DONE);
    end
  end

  assign in_ready    = w_in_ready;
  assign busy        = w_busy;
  assign done        = r_done;
  assign match_count = r_match_count;
  assign found       = r_found;
  assign first_idx   = r_first_idx;

endmodule
`default_nettype wire

// File: tb/tb_stream_key_matcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_key_matcher
//  Description : Self-checking bench for stream_key_matcher. Table of burst
//                vectors plus hand-written sequences for the zero-length
//                burst, reset mid-burst and ignored key_load/start.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_key_matcher;

  localparam int N  = 32;
  localparam int CW = 16;

  logic          clk;
  logic          rst;
  logic          key_load;
  logic [N-1:0]  key_in;
  logic          start;
  logic [CW-1:0] len;
  logic          in_valid;
  logic [N-1:0]  in_data;
  logic          in_ready;
  logic          busy;
  logic          done;
  logic [CW-1:0] match_count;
  logic          found;
  logic [CW-1:0] first_idx;

  int n_checks = 0;
  int n_fail   = 0;

  stream_key_matcher #(.N(N), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_load    (key_load),
    .key_in      (key_in),
    .start       (start),
    .len         (len),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .busy        (busy),
    .done        (done),
    .match_count (match_count),
    .found       (found),
    .first_idx   (first_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] key;
    int          blen;
    logic [31:0] data [6];
    int          gap;
    int          exp_cnt;
    logic        exp_found;
    int          exp_idx;
    int          exp_acc;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] k, input int blen, input bit load);
    key_load = load;
    key_in   = k;
    start    = 1'b1;
    len      = CW'(blen);
    tick();
    key_load = 1'b0;
    start    = 1'b0;
  endtask

  // Feeds words until blen are accepted or done appears. With noise set,
  // key_load and start are held high with junk values while words are offered.
  task automatic feed(input vec_t v, input bit noise, output int acc);
    int i;
    int budget;
    bit hs;
    i = 0;
    budget = 0;
    acc = 0;
    while (i < v.blen && budget < 300) begin
      in_valid = 1'b1;
      in_data  = v.data[i];
      if (noise) begin
        key_load = 1'b1;
        key_in   = ~v.key;
        start    = 1'b1;
        len      = 16'd2;
      end
      hs = in_ready;
      tick();
      budget++;
      if (hs) begin
        acc++;
        i++;
        in_valid = 1'b0;
        key_load = 1'b0;
        start    = 1'b0;
        if (done) break;
        if (i < v.blen) repeat (v.gap) tick();
      end
    end
    in_valid = 1'b0;
    key_load = 1'b0;
    start    = 1'b0;
  endtask

  task automatic run_vec(input string nm, input vec_t v, input bit noise, input bit load);
    int acc;
    do_start(v.key, v.blen, load);
    check({nm, " busy"}, busy, 1);
    feed(v, noise, acc);
    check({nm, " done latency"}, done, 1);
    check({nm, " accepted"}, acc, v.exp_acc);
    check({nm, " match_count"}, match_count, v.exp_cnt);
    check({nm, " found"}, found, v.exp_found);
    check({nm, " first_idx"}, first_idx, v.exp_idx);
    check({nm, " in_ready in done"}, in_ready, 0);
    tick();
    check({nm, " done one cycle"}, done, 0);
    check({nm, " idle"}, busy, 0);
  endtask

  initial begin
    vec_t t;
    int   acc;
    bit   saw_ready;
    bit   saw_done;

    rst = 1'b0; key_load = 1'b0; key_in = '0; start = 1'b0; len = '0;
    in_valid = 1'b0; in_data = '0;

    vecs[0] = '{key:32'hDEADBEEF, blen:4, data:'{32'h1, 32'hDEADBEEF, 32'h2, 32'hDEADBEEF, 32'h0, 32'h0},
                gap:0, exp_cnt:2, exp_found:1'b1, exp_idx:1, exp_acc:4};
    vecs[1] = '{key:32'h0, blen:3, data:'{32'h5, 32'h6, 32'h7, 32'h0, 32'h0, 32'h0},
                gap:2, exp_cnt:0, exp_found:1'b0, exp_idx:0, exp_acc:3};
`ifdef MATCH_EARLY_EXIT_EN
    vecs[2] = '{key:32'h9, blen:5, data:'{32'h3, 32'h9, 32'h9, 32'h4, 32'h9, 32'h0},
                gap:0, exp_cnt:1, exp_found:1'b1, exp_idx:1, exp_acc:2};
`else
    vecs[2] = '{key:32'h9, blen:5, data:'{32'h3, 32'h9, 32'h9, 32'h4, 32'h9, 32'h0},
                gap:0, exp_cnt:3, exp_found:1'b1, exp_idx:1, exp_acc:5};
`endif
    vecs[3] = '{key:32'hA5A5A5A5, blen:1, data:'{32'hA5A5A5A5, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                gap:0, exp_cnt:1, exp_found:1'b1, exp_idx:0, exp_acc:1};
    vecs[4] = '{key:32'hFFFFFFFF, blen:3, data:'{32'hFFFFFFFE, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0},
                gap:0, exp_cnt:1, exp_found:1'b1, exp_idx:2, exp_acc:3};
`ifdef MATCH_EARLY_EXIT_EN
    vecs[5] = '{key:32'h12345678, blen:6, data:'{32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678},
                gap:1, exp_cnt:1, exp_found:1'b1, exp_idx:0, exp_acc:1};
`else
    vecs[5] = '{key:32'h12345678, blen:6, data:'{32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678},
                gap:1, exp_cnt:6, exp_found:1'b1, exp_idx:0, exp_acc:6};
`endif

    // Reset state
    repeat (2) tick();
    check("reset match_count", match_count, 0);
    check("reset found", found, 0);
    check("reset first_idx", first_idx, 0);
    check("reset done", done, 0);
    check("reset busy", busy, 0);
    check("reset in_ready", in_ready, 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i], 1'b0, 1'b1);
      repeat (2) tick();
    end

    // Results are held in idle until the next start.
    check("held match_count", match_count, vecs[5].exp_cnt);
    check("held found", found, 1);

    // Zero-length burst
    saw_ready = 1'b0;
    do_start(32'h55, 0, 1'b1);
    saw_ready = saw_ready | in_ready;
    check("len0 done next cycle", done, 1);
    check("len0 match_count", match_count, 0);
    check("len0 found", found, 0);
    check("len0 first_idx", first_idx, 0);
    tick();
    saw_ready = saw_ready | in_ready;
    check("len0 done one cycle", done, 0);
    check("len0 in_ready never high", saw_ready, 0);

    // Reset during the second word of a len=4 burst
    do_start(32'hCAFE, 4, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'hCAFE;
    tick();
    check("pre-reset match_count", match_count, 1);
    in_data = 32'h3;
    #2 rst = 1'b0;
    #1;
    check("async reset match_count", match_count, 0);
    check("async reset found", found, 0);
    check("async reset busy", busy, 0);
    check("async reset in_ready", in_ready, 0);
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    saw_done = 1'b0;
    repeat (5) begin
      tick();
      saw_done = saw_done | done;
    end
    check("no done after reset abort", saw_done, 0);
    check("idle after reset", busy, 0);
    // Key was cleared by reset, so data 0 matches without a key_load.
    t = vecs[3];
    t.key = 32'h0; t.data[0] = 32'h0;
    t.exp_cnt = 1; t.exp_found = 1'b1; t.exp_idx = 0; t.exp_acc = 1;
    run_vec("post-reset", t, 1'b0, 1'b0);

    // key_load/start pulsed throughout SEARCH must be ignored
    t = vecs[1];
    t.key = 32'h5; t.blen = 3; t.gap = 0;
    t.data[0] = 32'h7; t.data[1] = 32'h5; t.data[2] = 32'h5;
`ifdef MATCH_EARLY_EXIT_EN
    t.exp_cnt = 1; t.exp_found = 1'b1; t.exp_idx = 1; t.exp_acc = 2;
`else
    t.exp_cnt = 2; t.exp_found = 1'b1; t.exp_idx = 1; t.exp_acc = 3;
`endif
    run_vec("noise", t, 1'b1, 1'b1);

    // Key register must still hold 5 (junk key_load was ignored).
    t.key = 32'h5; t.blen = 1; t.data[0] = 32'h5;
    t.exp_cnt = 1; t.exp_found = 1'b1; t.exp_idx = 0; t.exp_acc = 1;
    run_vec("key kept", t, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
